// File: rtl/zet_ng_wb_pkg.sv
// Shared types and bus geometry for the zet_ng Wishbone interconnect.
package zet_ng_wb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_FLUSH} arb_state_t;

  localparam int WB_AW = 20;
  localparam int WB_DW = 16;

endpackage

// File: rtl/zet_ng_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module zet_ng_rr_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = ptr;
    for (int i = 0; i < N; i++) begin
      k = (k == IW'(N - 1)) ? '0 : k + IW'(1);
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zet_ng_wb_arbiter.sv
// Round-robin Wishbone classic arbiter; the owner keeps the slave for its whole cyc,
// and a watchdog converts a silent slave into err followed by a flush.
//
//   state     | meaning
//   ARB_IDLE  | no owner; pick next requester after ptr
//   ARB_OWN   | master g drives the slave port, responses routed to g only
//   ARB_FLUSH | watchdog fired; slave port quiet until g drops cyc
module zet_ng_wb_arbiter
  import zet_ng_wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int SELW           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*SELW-1:0] m_sel_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [SELW-1:0]             s_sel_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int IW  = $clog2(NUM_MASTERS);
  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_MAX  = '1;

  arb_state_t             state, state_nxt;
  logic [IW-1:0]          g, ptr;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [WDW-1:0]         wdog, wdog_nxt;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;

  logic own_cyc, own_stb, resp, timeout;

  zet_ng_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_cyc = m_cyc_i[g];
  assign own_stb = m_stb_i[g];
  assign resp    = s_ack_i | s_err_i;
  // A response on the last allowed cycle beats the watchdog.
  assign timeout = (TIMEOUT_CYCLES > 0) && (state == ARB_OWN) && own_stb && !resp
                   && (wdog == WD_LAST);

  assign m_dat_o = s_dat_i;
  assign grant_o = (state == ARB_IDLE) ? '0 : grant_q;

  always_comb begin
    state_nxt = state;
    wdog_nxt  = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) state_nxt = ARB_OWN;
      end
      ARB_OWN: begin
        s_cyc_o    = own_cyc;
        s_stb_o    = own_stb;
        s_we_o     = m_we_i[g];
        s_adr_o    = m_adr_i[g*AW +: AW];
        s_dat_o    = m_dat_i[g*DW +: DW];
        s_sel_o    = m_sel_i[g*SELW +: SELW];
        m_ack_o[g] = s_ack_i;
        m_err_o[g] = s_err_i | timeout;
        if (!own_cyc)
          state_nxt = ARB_IDLE;
        else if (timeout)
          state_nxt = ARB_FLUSH;
        else if ((TIMEOUT_CYCLES > 0) && own_stb && !resp)
          wdog_nxt = (wdog == WD_MAX) ? wdog : wdog + WDW'(1);
      end
      ARB_FLUSH: begin
        if (!own_cyc) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= IW'(NUM_MASTERS - 1);
      g       <= '0;
      grant_q <= '0;
      wdog    <= '0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      if (state == ARB_IDLE && pick_any) begin
        g       <= pick_idx;
        grant_q <= pick_gnt;
      end
      if (state != ARB_IDLE && state_nxt == ARB_IDLE) ptr <= g;
    end
  end

endmodule
